seq_stage21_fifo_mem: RTL and testbench



---
 rtl/seq_stage21_fifo_mem_if.sv | 27 ++
 rtl/seq_stage21_fifo_mem.sv | 109 ++++++++++
 tb/tb_seq_stage21_fifo_mem.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/seq_stage21_fifo_mem_if.sv
// Handshake/status bundle for the seq_stage21_fifo_mem synchronous FIFO.
// master = producer/consumer side, slave = the FIFO itself.
interface seq_stage21_fifo_mem_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/seq_stage21_fifo_mem.sv
// Synchronous FIFO over a 2**ADDR_WIDTH-entry memory with a registered read port.
// Define SEQ_STAGE21_ERR_FLAGS_EN to build the sticky overflow/underflow registers.
module seq_stage21_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  seq_stage21_fifo_mem_if.slave   fifo_io
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  logic full, empty;
  logic wr_acc, rd_acc;

  // Flags come from the registered count only, never from this cycle's requests.
  assign full   = (count_q == FULL_COUNT);
  assign empty  = (count_q == '0);
  assign rd_acc = fifo_io.rd_en & ~empty;
  // A read in the same cycle frees a slot, so a full FIFO still takes the write.
  assign wr_acc = fifo_io.wr_en & (~full | rd_acc);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;

    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem_q[rd_ptr_q];
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; cleared pointers make stale words unreachable.
  // Same-slot read and write (only possible when full) returns the old word: the read samples before the write lands.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= fifo_io.wr_data;
  end

`ifdef SEQ_STAGE21_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (fifo_io.wr_en & ~wr_acc);
    underflow_d = underflow_q | (fifo_io.rd_en & empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign fifo_io.overflow  = overflow_q;
  assign fifo_io.underflow = underflow_q;
`else
  assign fifo_io.overflow  = 1'b0;
  assign fifo_io.underflow = 1'b0;
`endif

  assign fifo_io.rd_data  = rd_data_q;
  assign fifo_io.rd_valid = rd_valid_q;
  assign fifo_io.full     = full;
  assign fifo_io.empty    = empty;
  assign fifo_io.count    = count_q;

endmodule

// File: tb/tb_seq_stage21_fifo_mem.sv
// Self-checking bench for seq_stage21_fifo_mem: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_seq_stage21_fifo_mem;

`ifdef SEQ_STAGE21_ERR_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_stage21_fifo_mem_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  seq_stage21_fifo_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .fifo_io (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: contents as a queue, outputs derived from queue size.
  logic [7:0] q[$];
  logic [7:0] exp_data  = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_ovf   = 1'b0;
  logic       exp_unf   = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      exp_data  <= 8'h00;
      exp_valid <= 1'b0;
      exp_ovf   <= 1'b0;
      exp_unf   <= 1'b0;
    end else begin
      exp_valid <= bus.rd_en && q.size() != 0;
      exp_unf   <= exp_unf | (FLAGS_EN && bus.rd_en && q.size() == 0);
      exp_ovf   <= exp_ovf | (FLAGS_EN && bus.wr_en && !bus.rd_en && q.size() == 16);
      if (bus.rd_en && q.size() != 0) exp_data <= q.pop_front();
      if (bus.wr_en && q.size() < 16) q.push_back(bus.wr_data);
    end
  end

  always @(negedge clk) begin
    check("cmp_count",     32'(bus.count),     32'(q.size()));
    check("cmp_empty",     32'(bus.empty),     32'(q.size() == 0));
    check("cmp_full",      32'(bus.full),      32'(q.size() == 16));
    check("cmp_rd_valid",  32'(bus.rd_valid),  32'(exp_valid));
    check("cmp_rd_data",   32'(bus.rd_data),   32'(exp_data));
    check("cmp_overflow",  32'(bus.overflow),  32'(exp_ovf));
    check("cmp_underflow", 32'(bus.underflow), 32'(exp_unf));
  end

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_count",    32'(bus.count),    32'd0);
    check("reset_empty",    32'(bus.empty),    32'd1);
    check("reset_full",     32'(bus.full),     32'd0);
    check("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("reset_rd_data",  32'(bus.rd_data),  32'd0);

    // Three writes then three reads.
    cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0);
    check("w3_count", 32'(bus.count), 32'd3);
    cyc(0, 8'h00, 1);
    check("r1_data", 32'(bus.rd_data), 32'h11); check("r1_valid", 32'(bus.rd_valid), 32'd1);
    cyc(0, 8'h00, 1);
    check("r2_data", 32'(bus.rd_data), 32'h22); check("r2_valid", 32'(bus.rd_valid), 32'd1);
    cyc(0, 8'h00, 1);
    check("r3_data", 32'(bus.rd_data), 32'h33); check("r3_valid", 32'(bus.rd_valid), 32'd1);
    check("r3_count", 32'(bus.count), 32'd0);
    check("r3_empty", 32'(bus.empty), 32'd1);

    // Fill, overflow attempt, drain.
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0);
    check("fill_full",  32'(bus.full),  32'd1);
    check("fill_count", 32'(bus.count), 32'd16);
    cyc(1, 8'hAA, 0);
    check("ovf_flag",  32'(bus.overflow), 32'(FLAGS_EN));
    check("ovf_count", 32'(bus.count),    32'd16);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 8'h00, 1);
      check("drain_data", 32'(bus.rd_data), 32'(i));
    end
    check("drain_empty", 32'(bus.empty), 32'd1);

    // Simultaneous read/write while full.
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h10 + i), 0);
    cyc(1, 8'h5A, 1);
    check("fullrw_data",  32'(bus.rd_data), 32'h10);
    check("fullrw_count", 32'(bus.count),   32'd16);
    check("fullrw_full",  32'(bus.full),    32'd1);
    for (int i = 1; i < 16; i++) begin
      cyc(0, 8'h00, 1);
      check("fullrw_drain", 32'(bus.rd_data), 32'(8'h10 + i));
    end
    cyc(0, 8'h00, 1);
    check("fullrw_last", 32'(bus.rd_data), 32'h5A);

    // Read and write together while empty.
    cyc(1, 8'h77, 1);
    check("emptyrw_valid", 32'(bus.rd_valid),  32'd0);
    check("emptyrw_unf",   32'(bus.underflow), 32'(FLAGS_EN));
    check("emptyrw_count", 32'(bus.count),     32'd1);
    cyc(0, 8'h00, 1);
    check("emptyrw_next", 32'(bus.rd_data), 32'h77);

    // Pointer wrap: 40 write-then-read pairs.
    for (int i = 0; i < 40; i++) begin
      cyc(1, 8'(i), 0);
      cyc(0, 8'h00, 1);
      check("wrap_data", 32'(bus.rd_data), 32'(i));
    end

    // Asynchronous reset between edges.
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'hC0 + i), 0);
    #2 rst = 1'b1;
    #1;
    check("arst_count", 32'(bus.count),     32'd0);
    check("arst_empty", 32'(bus.empty),     32'd1);
    check("arst_valid", 32'(bus.rd_valid),  32'd0);
    check("arst_data",  32'(bus.rd_data),   32'd0);
    check("arst_ovf",   32'(bus.overflow),  32'd0);
    check("arst_unf",   32'(bus.underflow), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(0, 8'h00, 1);
    check("arst_read_valid", 32'(bus.rd_valid), 32'd0);

    // Randomized traffic checked by the per-cycle model compare.
    for (int i = 0; i < 800; i++) begin
      int bias;
      bias = (i / 200) % 2 == 0 ? 70 : 30;
      cyc(($urandom_range(99) < bias), 8'($urandom), ($urandom_range(99) < 100 - bias));
    end
    cyc(0, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
